// File: rtl/cmt_out_sequencer.sv
// Paces queued bytes into the CMT output port register as single-cycle Avalon-MM writes,
// one write every max(interval,1)+1 clocks while data is available and enable is high.
module cmt_out_sequencer #(
    parameter int FIFO_AW    = 3,
    parameter int INTERVAL_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [INTERVAL_W-1:0] interval,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [1:0]            av_address,
    output logic                  av_chipselect,
    output logic                  av_write_n,
    output logic [31:0]           av_writedata,
    output logic                  busy,
    output logic [FIFO_AW:0]      level
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

    state_t                state, state_nx;
    logic [7:0]            mem [DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
    logic [7:0]            wr_byte;
    logic [INTERVAL_W-1:0] cnt, cnt_nx, gap_len;
    logic                  push, pop;

    // in_ready looks only at the registered level, so a pop while full still frees a slot next cycle
    assign in_ready = (level != FULL);
    assign push     = in_valid & in_ready;
    assign gap_len  = (interval == '0) ? '0 : interval - 1'b1;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            wr_byte <= '0;
            state   <= IDLE;
            cnt     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                wr_byte <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (enable && level != '0) begin
                    pop      = 1'b1;
                    state_nx = STROBE;
                end
            end
            STROBE: begin
                // interval is captured only here; later changes do not stretch or cut the gap
                cnt_nx   = gap_len;
                state_nx = (gap_len != '0) ? GAP : IDLE;
            end
            GAP: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == INTERVAL_W'(1)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign av_address    = 2'b00;
    assign av_chipselect = (state == STROBE);
    assign av_write_n    = (state != STROBE);
    assign av_writedata  = (state == STROBE) ? {24'b0, wr_byte} : 32'b0;
    assign busy          = (level != '0) | (state != IDLE);

endmodule
